// File: rtl/io_bus_master_if.sv
// CPU request/response and peripheral strobe bus bundle.
// master: io_bus_master view; slave: CPU plus peripheral side.
interface io_bus_master_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        AS_L;
  logic        WE_L;
  logic [3:0]  sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq_n;
  logic        irq;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    input  bus_rdata, irq_n,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output AS_L, WE_L, sel, bus_wdata, irq
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    output bus_rdata, irq_n,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  AS_L, WE_L, sel, bus_wdata, irq
  );
endinterface

// File: rtl/io_bus_master.sv
// Bridges single CPU accesses onto a strobed 4-register peripheral bus.
// Ports: clk, reset (async high), bus (io_bus_master_if.master).
// Macro IO_BUS_IRQ_SYNC_EN: irq_n goes through a 2-flop synchronizer.
module io_bus_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
  input logic             clk,
  input logic             reset,
  io_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_STB,
    RD_CAP,
    RESP
  } state_t;

  state_t      state;
  logic        as_l;
  logic        we_l;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;
  logic        hit;
  logic [3:0]  sel_dec;
  logic        unused_addr_lsb;

  assign hit = bus.req_addr[31:4] == BASE_ADDR[31:4];
  assign unused_addr_lsb = &{1'b0, bus.req_addr[1:0]};

  always_comb begin
    sel_dec = 4'b0000;
    unique case (bus.req_addr[3:2])
      2'd0: sel_dec = 4'b0001;
      2'd1: sel_dec = 4'b0010;
      2'd2: sel_dec = 4'b0100;
      2'd3: sel_dec = 4'b1000;
      default: sel_dec = 4'b0000;
    endcase
  end

  // Strobe outputs default to idle every edge, so a strobe can only
  // last the single cycle it was loaded for; RESP/IDLE always sit
  // between two strobes and give peripherals their AS_L-high cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      as_l  <= 1'b1;
      we_l  <= 1'b1;
      sel   <= 4'b0000;
      wdata <= 32'h0;
      rdata <= 32'h0;
      err   <= 1'b0;
    end else begin
      as_l <= 1'b1;
      we_l <= 1'b1;
      sel  <= 4'b0000;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (hit) begin
              as_l <= 1'b0;
              sel  <= sel_dec;
              if (bus.req_we) begin
                we_l  <= 1'b0;
                wdata <= bus.req_wdata;
                state <= WR;
              end else begin
                state <= RD_STB;
              end
            end else begin
              err   <= 1'b1;
              rdata <= 32'h0;
              state <= RESP;
            end
          end
        end
        WR: begin
          err   <= 1'b0;
          rdata <= 32'h0;
          state <= RESP;
        end
        RD_STB: begin
          state <= RD_CAP;
        end
        RD_CAP: begin
          err   <= 1'b0;
          rdata <= bus.bus_rdata;
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;
  assign bus.AS_L      = as_l;
  assign bus.WE_L      = we_l;
  assign bus.sel       = sel;
  assign bus.bus_wdata = wdata;

`ifdef IO_BUS_IRQ_SYNC_EN
  logic [1:0] irq_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_sync <= 2'b11;
    end else begin
      irq_sync <= {irq_sync[0], bus.irq_n};
    end
  end

  assign bus.irq = ~irq_sync[1];
`else
  // Zero-latency path; gated so reset still holds irq low.
  assign bus.irq = ~bus.irq_n & ~reset;
`endif

endmodule
